// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I MEM-stage load/store unit driving the data-cache port
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_mbe,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      r_state;
  logic        r_done;
  logic        r_fault;
  logic [31:0] r_load_data;
  logic [31:0] r_address;
  logic        r_read;
  logic        r_write;
  logic [3:0]  r_mbe;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misaligned;
  logic [3:0]  w_mbe;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  // The ~done term keeps the instruction that is completing from being taken again
  assign stall    = req_valid & ~r_done;
  assign w_accept = (r_state == IDLE) & req_valid & ~r_done;

  assign done         = r_done;
  assign fault        = r_fault;
  assign load_data    = r_load_data;
  assign dmem_address = r_address;
  assign dmem_read    = r_read;
  assign dmem_write   = r_write;
  assign dmem_mbe     = r_mbe;
  assign dmem_wdata   = r_wdata;

  // Decode illegal op kinds/funct3 and natural-alignment violations of the incoming request
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    if (req_load == req_store) begin
      w_illegal = 1'b1;
    end else if (req_load) begin
      w_illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
    end else begin
      w_illegal = (req_funct3 >= 3'b011);
    end
    case (req_funct3[1:0])
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = |req_addr[1:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  // Build byte enables and lane-replicated store data so any lane the cache picks is correct
  always_comb begin
    w_mbe   = 4'b0000;
    w_wdata = 32'h0;
    if (req_store) begin
      case (req_funct3[1:0])
        2'b00: begin
          w_mbe   = 4'b0001 << req_addr[1:0];
          w_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          w_mbe   = 4'b0011 << {req_addr[1], 1'b0};
          w_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          w_mbe   = 4'b1111;
          w_wdata = req_wdata;
        end
      endcase
    end
  end

  // Select the addressed byte/half of the returned word and extend it per the latched funct3
  always_comb begin
    w_byte = 8'h0;
    case (r_off)
      2'd0: w_byte = dmem_rdata[7:0];
      2'd1: w_byte = dmem_rdata[15:8];
      2'd2: w_byte = dmem_rdata[23:16];
      2'd3: w_byte = dmem_rdata[31:24];
      default: w_byte = 8'h0;
    endcase
    w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {24'h0, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_ext = {16'h0, w_half};
      default: w_load_ext = dmem_rdata;
    endcase
  end

  // IDLE/BUSY control: accept, issue the cache request, wait for the response, pulse done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_load_data <= 32'h0;
      r_address   <= 32'h0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_mbe       <= 4'b0000;
      r_wdata     <= 32'h0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_illegal | w_misaligned) begin
              r_done      <= 1'b1;
              r_fault     <= 1'b1;
              r_load_data <= 32'h0;
            end else begin
              r_state   <= BUSY;
              r_read    <= req_load;
              r_write   <= req_store;
              r_address <= {req_addr[31:2], 2'b00};
              r_mbe     <= w_mbe;
              r_wdata   <= w_wdata;
              r_funct3  <= req_funct3;
              r_off     <= req_addr[1:0];
            end
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            r_state <= IDLE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_done  <= 1'b1;
            if (r_read) begin
              r_load_data <= w_load_ext;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
